// File: rtl/escalator_pkg.sv
// Shared definitions for the escalator drive ramp controller.
//   state_t    : 3-bit FSM state encoding (codes 6 and 7 are unused)
//   SPEED_W    : width of the speed / PWM counter datapath
//   PWM_PERIOD : PWM frame length in clock cycles
//   speed_inc / speed_dec : saturating step helpers
package escalator_pkg;

  localparam int SPEED_W    = 4;
  localparam int PWM_PERIOD = 15;

  localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(15);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_RUN   = 3'd2,
    ST_DECEL = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ESTOP = 3'd5
  } state_t;

  function automatic logic [SPEED_W-1:0] speed_inc(input logic [SPEED_W-1:0] s);
    return (s == SPEED_TOP) ? s : s + 1'b1;
  endfunction

  function automatic logic [SPEED_W-1:0] speed_dec(input logic [SPEED_W-1:0] s);
    return (s == '0) ? s : s - 1'b1;
  endfunction

endpackage

// File: rtl/escalator_tick_gen.sv
// Ramp prescaler: counts 0..TICK_DIV-1 while ena is high and emits a
// one-cycle tick on the terminal count, then wraps to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ena   : count enable; low freezes the count and suppresses tick
//   tick  : ramp step strobe
module escalator_tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = ena && (cnt == CNT_LAST);

endmodule

// File: rtl/escalator_drive_ramp.sv
// Escalator motor drive ramp controller.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ena        : freezes prescaler, ramp and PWM counters when low
//   run_req    : run command, dir_req : requested direction (1 = up)
//   estop      : emergency stop, highest priority
//   speed_max  : target speed 0..15
//   pwm        : motor drive PWM, dir_out : applied direction
//   brake      : mechanical brake engaged, at_speed : high in RUN
//   speed      : current ramped speed, state : FSM state code
//
// state | meaning
// IDLE  | stopped, brake engaged, waiting for a run command
// ACCEL | ramping speed up one step per tick
// RUN   | at target speed
// DECEL | ramping speed down one step per tick
// HOLD  | brake dwell after reaching zero, run_req ignored
// ESTOP | emergency stop latched until estop and run_req both drop
module escalator_drive_ramp
  import escalator_pkg::*;
#(
  parameter int TICK_DIV   = 1024,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               run_req,
  input  logic               dir_req,
  input  logic               estop,
  input  logic [SPEED_W-1:0] speed_max,
  output logic               pwm,
  output logic               dir_out,
  output logic               brake,
  output logic               at_speed,
  output logic [SPEED_W-1:0] speed,
  output logic [2:0]         state
);

  localparam int                HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [SPEED_W-1:0] PWM_LAST  = SPEED_W'(PWM_PERIOD - 1);

  state_t             st;
  logic               tick;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SPEED_W-1:0] pwm_cnt;
  logic               abort;
  logic               resume_ok;

  escalator_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  assign abort     = !run_req || (dir_req != dir_out);
  assign resume_ok = run_req && (dir_req == dir_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      speed    <= '0;
      dir_out  <= 1'b1;
      brake    <= 1'b1;
      at_speed <= 1'b0;
      hold_cnt <= '0;
    end else if (estop) begin
      st       <= ST_ESTOP;
      speed    <= '0;
      brake    <= 1'b1;
      at_speed <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          speed    <= '0;
          brake    <= 1'b1;
          at_speed <= 1'b0;
          if (run_req && (speed_max != '0)) begin
            st      <= ST_ACCEL;
            dir_out <= dir_req;
            brake   <= 1'b0;
          end
        end
        ST_ACCEL: begin
          if (abort || (speed > speed_max)) begin
            st <= ST_DECEL;
          end else if (speed == speed_max) begin
            st       <= ST_RUN;
            at_speed <= 1'b1;
          end else if (tick) begin
            speed <= speed_inc(speed);
            // enter RUN on the same edge as the final increment
            if (speed_inc(speed) == speed_max) begin
              st       <= ST_RUN;
              at_speed <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          at_speed <= 1'b1;
          if (abort || (speed > speed_max)) begin
            st       <= ST_DECEL;
            at_speed <= 1'b0;
          end else if (speed < speed_max) begin
            st       <= ST_ACCEL;
            at_speed <= 1'b0;
          end
        end
        ST_DECEL: begin
          if (speed == '0) begin
            st       <= ST_HOLD;
            brake    <= 1'b1;
            hold_cnt <= HOLD_LOAD;
          end else if (resume_ok && (speed_max > speed)) begin
            st <= ST_ACCEL;
          end else if (resume_ok && (speed == speed_max)) begin
            st       <= ST_RUN;
            at_speed <= 1'b1;
          end else if (tick) begin
            speed <= speed_dec(speed);
            if (speed == SPEED_W'(1)) begin
              st       <= ST_HOLD;
              brake    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          speed <= '0;
          brake <= 1'b1;
          if (tick) begin
            if (hold_cnt == '0) st <= ST_IDLE;
            else hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_ESTOP: begin
          speed <= '0;
          brake <= 1'b1;
          if (!run_req) st <= ST_IDLE;
        end
        default: begin
          st       <= ST_ESTOP;
          speed    <= '0;
          brake    <= 1'b1;
          at_speed <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (ena) begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  // decoded from registers only, so it drops on the same edge the brake engages
  assign pwm   = !brake && (pwm_cnt < speed);
  assign state = st;

endmodule

// File: tb/tb_escalator_drive_ramp.sv
module tb_escalator_drive_ramp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       run_req = 1'b0;
  logic       dir_req = 1'b1;
  logic       estop = 1'b0;
  logic [3:0] speed_max = 4'd0;
  logic       pwm, dir_out, brake, at_speed;
  logic [3:0] speed;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [9:0] exp_q[$];

  escalator_drive_ramp #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .run_req   (run_req),
    .dir_req   (dir_req),
    .estop     (estop),
    .speed_max (speed_max),
    .pwm       (pwm),
    .dir_out   (dir_out),
    .brake     (brake),
    .at_speed  (at_speed),
    .speed     (speed),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] tup(input int st, input int spd, input int d,
                                     input int brk, input int at);
    return {st[2:0], spd[3:0], d[0], brk[0], at[0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int st, input int spd, input int d, input int brk, input int at);
    exp_q.push_back(tup(st, spd, d, brk, at));
  endtask

  task automatic push_up(input int a, input int b, input int d);
    for (int s = a; s <= b; s++) push(1, s, d, 0, 0);
  endtask

  task automatic push_down(input int a, input int b, input int d);
    for (int s = a; s >= b; s--) push(3, s, d, 0, 0);
  endtask

  task automatic wait_for(input int st, input int spd, input string name, output int n);
    n = 0;
    while (!((state == 3'(st)) && (speed == 4'(spd))) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for state %0d speed %0d (state %0d speed %0d)",
               name, st, spd, state, speed);
    end
  endtask

  task automatic pwm_window(input string name, input int exp_high);
    int hi;
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (pwm) hi++;
    end
    chk(name, hi, exp_high);
  endtask

  // Scoreboard monitor: every change of the observable state tuple pops one expectation.
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] prev;
    logic [9:0] e;
    cur = {state, speed, dir_out, brake, at_speed};
    if (mon_en && (cur !== prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no change", cur);
      end else begin
        e = exp_q.pop_front();
        chk("sb_seq", int'(cur), int'(e));
      end
    end
    prev = cur;
  end

  initial begin
    int n;
    int hi;
    logic pwm0;
    logic pwm_steady;

    repeat (3) @(negedge clk);
    chk("reset_tuple", int'({state, speed, dir_out, brake, at_speed}), int'(tup(0, 0, 1, 1, 0)));
    chk("reset_pwm", int'(pwm), 0);

    // ramp up to 5, direction up
    push(1, 0, 1, 0, 0);
    push_up(1, 4, 1);
    push(2, 5, 1, 0, 1);
    mon_en = 1'b1;
    rst_n = 1'b1;
    run_req = 1'b1;
    dir_req = 1'b1;
    speed_max = 4'd5;
    wait_for(2, 5, "accel_to_5", n);
    chk("accel_cycles", n, 20);
    chk("run_dir_brake", int'({dir_out, brake}), 2);

    // reversal through HOLD, then accelerate downwards
    push_down(5, 1, 1);
    push(4, 0, 1, 1, 0);
    push(0, 0, 1, 1, 0);
    push(1, 0, 0, 0, 0);
    push_up(1, 4, 0);
    push(2, 5, 0, 0, 1);
    dir_req = 1'b0;
    wait_for(4, 0, "decel_to_hold", n);
    n = 0;
    while ((state == 3'd4) && (n < 50)) begin
      chk("hold_brake", int'(brake), 1);
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", n, 8);
    wait_for(2, 5, "reaccel_down", n);
    chk("dir_down", int'(dir_out), 0);

    // target changes while running
    push_up(5, 9, 0);
    push(2, 10, 0, 0, 1);
    speed_max = 4'd10;
    wait_for(2, 10, "run_10", n);
    push_down(10, 4, 0);
    push(2, 4, 0, 0, 1);
    speed_max = 4'd4;
    wait_for(2, 4, "lower_to_4", n);
    push_up(4, 11, 0);
    push(2, 12, 0, 0, 1);
    speed_max = 4'd12;
    wait_for(2, 12, "raise_to_12", n);

    // PWM duty
    push_down(12, 8, 0);
    push(2, 8, 0, 0, 1);
    speed_max = 4'd8;
    wait_for(2, 8, "run_8", n);
    pwm_window("pwm_speed8", 8);
    push_up(8, 14, 0);
    push(2, 15, 0, 0, 1);
    speed_max = 4'd15;
    wait_for(2, 15, "run_15", n);
    pwm_window("pwm_speed15", 15);

    // emergency stop at speed 7
    push_down(15, 7, 0);
    push(2, 7, 0, 0, 1);
    speed_max = 4'd7;
    wait_for(2, 7, "run_7", n);
    push(5, 0, 0, 1, 0);
    estop = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    chk("estop_tuple", int'({state, speed, brake, pwm}), int'({3'd5, 4'd0, 1'b1, 1'b0}));
    pwm_window("pwm_speed0", 0);
    chk("estop_held", int'(state), 5);
    push(0, 0, 0, 1, 0);
    run_req = 1'b0;
    wait_for(0, 0, "estop_exit", n);

    // restart, freeze with ena=0 mid-ramp, then async reset mid-ACCEL
    push(1, 0, 0, 0, 0);
    push_up(1, 6, 0);
    push(0, 0, 1, 1, 0);
    run_req = 1'b1;
    speed_max = 4'd10;
    wait_for(1, 3, "accel_to_3", n);
    ena = 1'b0;
    @(negedge clk);
    pwm0 = pwm;
    pwm_steady = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm !== pwm0) pwm_steady = 1'b0;
      if (pwm) hi++;
    end
    chk("ena0_speed", int'(speed), 3);
    chk("ena0_pwm_frozen", int'(pwm_steady), 1);
    ena = 1'b1;
    wait_for(1, 6, "accel_to_6", n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({state, speed, dir_out, brake, at_speed, pwm}),
        int'({tup(0, 0, 1, 1, 0), 1'b0}));
    @(negedge clk);
    run_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", int'(state), 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/escalator_drive_ramp.md
ESCALATOR_DRIVE_RAMP -- requirements
Module: escalator_drive_ramp

Interface
REQ-001 Parameter TICK_DIV, default 1024, clock cycles per ramp step (>=2).
REQ-002 Parameter HOLD_TICKS, default 4, ramp ticks of brake dwell after reaching zero speed (>=1).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  enable; low freezes prescaler, ramp and PWM counters (estop still honoured).
REQ-006 run_req  input  1  run command from escalator controller.
REQ-007 dir_req  input  1  requested direction, 1 = up.
REQ-008 estop  input  1  emergency stop, synchronous level, highest priority.
REQ-009 speed_max  input  4  target speed 0..15.
REQ-010 pwm  output  1  motor drive PWM.
REQ-011 dir_out  output  1  applied direction, 1 = up.
REQ-012 brake  output  1  mechanical brake engage, 1 = engaged.
REQ-013 at_speed  output  1  high when in RUN.
REQ-014 speed  output  4  current ramped speed.
REQ-015 state  output  3  FSM state code.

Function
REQ-016 Prescaler counts 0..TICK_DIV-1 while ena=1; tick is a one-cycle pulse when count = TICK_DIV-1, then count wraps to 0.
REQ-017 States/codes: IDLE=0, ACCEL=1, RUN=2, DECEL=3, HOLD=4, ESTOP=5; codes 6,7 unused and SHALL go to ESTOP.
REQ-018 IDLE: brake=1, speed=0; run_req=1 and speed_max!=0 -> ACCEL, dir_out <= dir_req in the same cycle.
REQ-019 dir_out SHALL change only on the IDLE->ACCEL transition.
REQ-020 ACCEL: brake=0; on tick speed+1; when speed reaches speed_max -> RUN (same cycle as the final increment).
REQ-021 ACCEL/RUN: run_req=0 or dir_req!=dir_out -> DECEL next cycle.
REQ-022 RUN: speed<speed_max -> ACCEL; speed>speed_max -> DECEL.
REQ-023 DECEL: on tick speed-1; when speed=0 -> HOLD; if run_req=1, dir_req=dir_out and speed_max>speed -> ACCEL; if speed=speed_max and run_req=1, dir matching -> RUN.
REQ-024 HOLD: brake=1, speed=0; after HOLD_TICKS ticks -> IDLE; run_req SHALL be ignored until IDLE (direction reversal always passes through HOLD).
REQ-025 Speed SHALL saturate at 0 and 15; never wrap.
REQ-026 estop=1 in any state -> ESTOP next cycle: speed=0, pwm=0, brake=1 at that edge.
REQ-027 ESTOP exits to IDLE only when estop=0 and run_req=0.
REQ-028 PWM: 4-bit counter 0..14 (period 15 cycles), advancing when ena=1; pwm=1 iff counter < speed (speed 15 = 100 %, 0 = 0 %).
REQ-029 pwm SHALL be 0 whenever brake=1.
REQ-030 at_speed = (state==RUN), registered with state.
REQ-031 Tick and state change in the same cycle SHALL use the new state only from the next cycle.

Reset
REQ-032 rst_n low asynchronously forces: state=IDLE, speed=0, dir_out=1, brake=1, pwm=0, at_speed=0, prescaler=0, PWM counter=0, hold counter=0.
REQ-033 Reset mid-ramp SHALL take effect immediately without waiting for clk; release resumes in IDLE.

Structure
REQ-034 Package escalator_pkg SHALL hold the state enum (3-bit), SPEED_W=4, PWM_PERIOD=15.
REQ-035 Prescaler SHALL be sub-module escalator_tick_gen (params TICK_DIV; ports clk, rst_n, ena, tick).
REQ-036 Implementation 120-400 lines, single clock domain, no latches.

Verification (TICK_DIV=4, HOLD_TICKS=2)
REQ-037 Reset, run_req=1, dir_req=1, speed_max=5 -> speed 1..5 on successive ticks, RUN after 5 ticks (~20 cycles), dir_out=1, brake=0.
REQ-038 In RUN at 5, dir_req=0 -> DECEL 5..0, HOLD 2 ticks with brake=1, IDLE, then ACCEL with dir_out=0.
REQ-039 speed=8, 15-cycle window -> pwm high exactly 8 cycles; speed=15 -> pwm constantly 1; speed=0 -> 0.
REQ-040 estop pulse at speed 7 -> next cycle speed=0, pwm=0, brake=1, state=5; stays ESTOP while run_req=1; IDLE after estop=0, run_req=0.
REQ-041 RUN at 10, speed_max lowered to 4 -> DECEL to 4 then RUN; raised to 12 -> ACCEL to 12.
REQ-042 rst_n asserted mid-ACCEL between clock edges -> outputs at reset values before next edge; ena=0 holds speed and PWM count unchanged.
